count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Downstream checker/statistics stage for the free-running 5-bit counter.
- Samples the counter value every qualified cycle and verifies strict +1 (mod 2^CNT_W) progression.
- Counts wrap-arounds and sequence errors, raises a sticky error flag, and re-locks automatically after a disturbance.
- Sits directly after the counter; its outputs feed status registers and debug logic.

Parameters:
- CNT_W, 5, width of the monitored count bus.
- WRAP_W, 8, width of the wrap-around tally (saturating).
- ERR_W, 8, width of the error tally (saturating).
- RELOCK_N, 2, consecutive correct increments needed in RESYNC before returning to LOCK (range 1..7).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_in  input  CNT_W  count value from the upstream counter.
- cnt_valid  input  1  cnt_in is meaningful this cycle; low while the counter is held in reset.
- clr  input  1  synchronous clear of statistics and state.
- wrap_pulse  output  1  one-cycle pulse: a valid max->0 transition was accepted in LOCK.
- wrap_total  output  WRAP_W  saturating count of accepted wraps.
- err_total  output  ERR_W  saturating count of sequence errors detected in LOCK.
- err_flag  output  1  sticky; set on the first error, cleared only by clr or reset.
- state  output  2  00 SYNC, 01 LOCK, 10 RESYNC (11 unused, decodes to SYNC).
- last_cnt  output  CNT_W  most recent accepted sample (the reference value).

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state = SYNC, internal relock counter = 0. No clock is needed for reset to take effect.
- All outputs are registered. Responses appear on the edge that samples the qualifying input (1-cycle latency).
- Define exp = last_cnt + 1, truncated to CNT_W bits, so max wraps to 0.
- cnt_valid low: all state and statistics hold; wrap_pulse = 0.
- clr high: takes priority over cnt_valid in the same cycle.
  - Clears wrap_total, err_total, err_flag, last_cnt and the relock counter.
  - Sets state = SYNC and wrap_pulse = 0.
- SYNC, cnt_valid high: last_cnt <= cnt_in; go to LOCK. No check is made and no statistics change.
- LOCK, cnt_valid high, cnt_in == exp:
  - last_cnt <= cnt_in; stay in LOCK.
  - If last_cnt == all-ones (so cnt_in == 0): wrap_pulse = 1 next cycle; wrap_total += 1, saturating at all-ones.
- LOCK, cnt_valid high, cnt_in != exp (this includes a repeated value or a skip):
  - err_total += 1, saturating; err_flag <= 1.
  - last_cnt <= cnt_in; relock counter <= 0; go to RESYNC.
- RESYNC, cnt_valid high:
  - Always: last_cnt <= cnt_in.
  - cnt_in == exp: relock counter += 1. When it reaches RELOCK_N, go to LOCK and reset the counter to 0.
  - cnt_in != exp: relock counter <= 0; stay in RESYNC; err_total is not incremented (prevents cascading counts).
- Wraps seen in RESYNC or SYNC are not counted and produce no pulse. The increment that completes relock is also not counted as a wrap.
- Saturation: both totals stick at all-ones and never roll over. err_flag stays 1 regardless.
- cnt_in is not qualified by parity or range. Any CNT_W value is legal as a first sample.

Test Plan:
- Reset, then valid stream 0,1,...,31,0,1 (34 samples) -> state 01 from the 2nd cycle; exactly one wrap_pulse, one cycle after sample 0 follows 31; wrap_total = 1; err_total = 0; err_flag = 0.
- LOCK at 5, then drive 7 (skip) -> err_total = 1, err_flag = 1, state = 10. Then 8,9 -> state = 01 after 9; err_total stays 1.
- In RESYNC drive 3,3,4,4,5,6 -> state = 01 only after 5,6; err_total unchanged throughout RESYNC; repeated values reset the relock counter.
- Run 300 full wraps with WRAP_W=8 -> wrap_total saturates at 255 and wrap_pulse keeps pulsing. Then force 300 skip/relock cycles -> err_total saturates at 255.
- cnt_valid low for 10 cycles mid-stream at value 12, resume at 13 -> no error; all outputs held during the gap.
- Assert clr in the same cycle as a valid mismatching sample -> state = 00, all totals 0, err_flag 0. Assert rst_n low asynchronously between clock edges mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_monitor.sv
// count_monitor: checks that a free-running counter advances by exactly +1
// (mod 2^CNT_W) on every qualified cycle. It keeps saturating tallies of wraps
// and sequence errors and a sticky error flag. After an error it waits in
// RESYNC until the stream is clean again, then returns to LOCK.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cnt_in     sampled count value
//   cnt_valid  cnt_in is meaningful this cycle
//   clr        synchronous clear of statistics and state (beats cnt_valid)
//   wrap_pulse one-cycle pulse for an accepted max->0 step while locked
//   wrap_total saturating tally of accepted wraps
//   err_total  saturating tally of errors detected while locked
//   err_flag   sticky error indicator
//   state      00 SYNC, 01 LOCK, 10 RESYNC
//   last_cnt   most recently accepted sample (the reference value)
module count_monitor #(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned RELOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_total,
  output logic [ERR_W-1:0]  err_total,
  output logic              err_flag,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  last_cnt
);

  localparam logic [1:0] StSync   = 2'b00;
  localparam logic [1:0] StLock   = 2'b01;
  localparam logic [1:0] StResync = 2'b10;

  localparam logic [2:0] RelockMax = 3'(RELOCK_N);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [2:0]        relock_q, relock_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              flag_q, flag_d;
  logic              pulse_q, pulse_d;

  logic [CNT_W-1:0]  exp_cnt;
  logic              match;

  assign exp_cnt = last_q + CNT_W'(1);
  assign match   = (cnt_in == exp_cnt);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    relock_d = relock_q;
    wrap_d   = wrap_q;
    err_d    = err_q;
    flag_d   = flag_q;
    pulse_d  = 1'b0;

    if (clr) begin
      state_d  = StSync;
      last_d   = '0;
      relock_d = '0;
      wrap_d   = '0;
      err_d    = '0;
      flag_d   = 1'b0;
    end else if (cnt_valid) begin
      // Every qualified sample becomes the new reference, whatever the state.
      last_d = cnt_in;
      case (state_q)
        StLock: begin
          if (match) begin
            if (last_q == '1) begin
              pulse_d = 1'b1;
              if (wrap_q != '1) wrap_d = wrap_q + WRAP_W'(1);
            end
          end else begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            flag_d   = 1'b1;
            relock_d = '0;
            state_d  = StResync;
          end
        end
        StResync: begin
          // Errors are not tallied here so a single disturbance counts once.
          if (match) begin
            if (relock_q + 3'd1 == RelockMax) begin
              relock_d = '0;
              state_d  = StLock;
            end else begin
              relock_d = relock_q + 3'd1;
            end
          end else begin
            relock_d = '0;
          end
        end
        default: begin
          // SYNC and the unused encoding: take the first sample unchecked.
          relock_d = '0;
          state_d  = StLock;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSync;
      last_q   <= '0;
      relock_q <= '0;
      wrap_q   <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      relock_q <= relock_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      pulse_q  <= pulse_d;
    end
  end

  assign wrap_pulse = pulse_q;
  assign wrap_total = wrap_q;
  assign err_total  = err_q;
  assign err_flag   = flag_q;
  assign state      = state_q;
  assign last_cnt   = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed steps in one initial block. Each driven
// sample pushes the expected register contents onto a scoreboard queue; the
// entry is popped and compared one edge later.
module tb_count_monitor;

  logic       clk;
  logic       rst_n;
  logic [4:0] cnt_in;
  logic       cnt_valid;
  logic       clr;
  logic       wrap_pulse;
  logic [7:0] wrap_total;
  logic [7:0] err_total;
  logic       err_flag;
  logic [1:0] state;
  logic [4:0] last_cnt;

  count_monitor #(
    .CNT_W   (5),
    .WRAP_W  (8),
    .ERR_W   (8),
    .RELOCK_N(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .clr       (clr),
    .wrap_pulse(wrap_pulse),
    .wrap_total(wrap_total),
    .err_total (err_total),
    .err_flag  (err_flag),
    .state     (state),
    .last_cnt  (last_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] last;
    logic       pulse;
    logic [7:0] wrap;
    logic [7:0] err;
    logic       flag;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model state
  logic [1:0] m_state;
  logic [4:0] m_last;
  int         m_rel;
  logic [7:0] m_wrap;
  logic [7:0] m_err;
  logic       m_flag;
  logic       m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00; m_last = '0; m_rel = 0;
    m_wrap = '0; m_err = '0; m_flag = 1'b0; m_pulse = 1'b0;
  endtask

  // Drive one cycle, predict, then compare one edge later.
  task automatic drive(input logic v, input logic [4:0] c, input logic cl);
    exp_t       e;
    logic [4:0] nxt;
    cnt_valid = v;
    cnt_in    = c;
    clr       = cl;
    nxt       = m_last + 5'd1;
    m_pulse   = 1'b0;
    if (cl) begin
      m_state = 2'b00; m_last = '0; m_rel = 0;
      m_wrap = '0; m_err = '0; m_flag = 1'b0;
    end else if (v) begin
      if (m_state == 2'b01) begin
        if (c == nxt) begin
          if (m_last == 5'd31) begin
            m_pulse = 1'b1;
            if (m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
          end
        end else begin
          if (m_err != 8'd255) m_err = m_err + 8'd1;
          m_flag  = 1'b1;
          m_rel   = 0;
          m_state = 2'b10;
        end
      end else if (m_state == 2'b10) begin
        if (c == nxt) begin
          m_rel++;
          if (m_rel == 2) begin
            m_rel   = 0;
            m_state = 2'b01;
          end
        end else begin
          m_rel = 0;
        end
      end else begin
        m_state = 2'b01;
        m_rel   = 0;
      end
      m_last = c;
    end
    sb.push_back('{m_state, m_last, m_pulse, m_wrap, m_err, m_flag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("last_cnt", 32'(last_cnt), 32'(e.last));
    check("wrap_pulse", 32'(wrap_pulse), 32'(e.pulse));
    check("wrap_total", 32'(wrap_total), 32'(e.wrap));
    check("err_total", 32'(err_total), 32'(e.err));
    check("err_flag", 32'(err_flag), 32'(e.flag));
    if (wrap_pulse) pulses++;
  endtask

  task automatic run_seq(input int start, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 5'((start + i) % 32), 1'b0);
  endtask

  initial begin
    model_reset();
    cnt_in    = '0;
    cnt_valid = 1'b0;
    clr       = 1'b0;
    rst_n     = 1'b0;
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'({wrap_pulse, wrap_total, err_total, err_flag, last_cnt}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean stream 0..31,0,1: one wrap, no errors.
    pulses = 0;
    drive(1'b1, 5'd0, 1'b0);
    check("lock_after_first", 32'(state), 32'd1);
    run_seq(1, 33);
    check("stream_pulses", 32'(pulses), 32'd1);
    check("stream_wrap_total", 32'(wrap_total), 32'd1);
    check("stream_err_total", 32'(err_total), 32'd0);
    check("stream_err_flag", 32'(err_flag), 32'd0);

    // Skip 5 -> 7, then relock on 8,9.
    run_seq(2, 4);
    drive(1'b1, 5'd7, 1'b0);
    check("skip_err_total", 32'(err_total), 32'd1);
    check("skip_err_flag", 32'(err_flag), 32'd1);
    check("skip_state", 32'(state), 32'd2);
    drive(1'b1, 5'd8, 1'b0);
    check("relock_mid_state", 32'(state), 32'd2);
    drive(1'b1, 5'd9, 1'b0);
    check("relock_state", 32'(state), 32'd1);
    check("relock_err_total", 32'(err_total), 32'd1);

    // Enter RESYNC, then 3,3,4,4,5,6: repeats reset the relock count.
    drive(1'b1, 5'd10, 1'b0);
    drive(1'b1, 5'd20, 1'b0);
    check("resync_entry_err", 32'(err_total), 32'd2);
    drive(1'b1, 5'd3, 1'b0);
    drive(1'b1, 5'd3, 1'b0);
    drive(1'b1, 5'd4, 1'b0);
    drive(1'b1, 5'd4, 1'b0);
    drive(1'b1, 5'd5, 1'b0);
    check("resync_after_5", 32'(state), 32'd2);
    check("resync_err_held", 32'(err_total), 32'd2);
    drive(1'b1, 5'd6, 1'b0);
    check("resync_after_6", 32'(state), 32'd1);

    // Valid gap at 12 for 10 cycles, resume at 13.
    run_seq(7, 6);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'(i * 7), 1'b0);
      check("gap_last_held", 32'(last_cnt), 32'd12);
    end
    drive(1'b1, 5'd13, 1'b0);
    check("gap_resume_err", 32'(err_total), 32'd2);
    check("gap_resume_state", 32'(state), 32'd1);

    // 300 full wraps: wrap_total saturates, pulses continue.
    run_seq(14, 18);
    pulses = 0;
    for (int w = 0; w < 300; w++) run_seq(0, 32);
    check("wrap_pulse_count", 32'(pulses), 32'd300);
    check("wrap_saturated", 32'(wrap_total), 32'd255);

    // 300 skip/relock cycles: err_total saturates.
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, m_last + 5'd2, 1'b0);
      drive(1'b1, m_last + 5'd1, 1'b0);
      drive(1'b1, m_last + 5'd1, 1'b0);
    end
    check("err_saturated", 32'(err_total), 32'd255);
    check("err_sat_state", 32'(state), 32'd1);

    // Random mix, including wraps during relock and occasional clears.
    for (int r = 0; r < 400; r++) begin
      logic [4:0] c;
      c = ($urandom_range(0, 3) == 0) ? 5'($urandom) : m_last + 5'd1;
      drive(($urandom_range(0, 7) != 0), c, ($urandom_range(0, 60) == 0));
    end

    // clr together with a mismatching valid sample.
    drive(1'b1, m_last + 5'd5, 1'b1);
    check("clr_state", 32'(state), 32'd0);
    check("clr_totals", 32'({wrap_total, err_total}), 32'd0);
    check("clr_flag", 32'(err_flag), 32'd0);

    // Asynchronous reset between edges.
    run_seq(20, 15);
    cnt_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_outputs", 32'({wrap_pulse, wrap_total, err_total, err_flag, last_cnt}), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_seq(9, 5);
    check("post_reset_state", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
